// File: rtl/orb_pkg.sv
// Shared definitions for the orbit frame filler and its helpers.
// Holds frame geometry constants, the filler state type and the
// header-word packing function.
package orb_pkg;

    localparam int WORDS    = 2048;
    localparam int AW       = 11;
    localparam int WORD_W   = 12;
    localparam int MARK_BIT = 11;
    localparam int FRM_W    = 7;

    typedef enum logic [1:0] {
        CLEAR,
        HDR,
        FILL,
        FULL
    } fillState_t;

    // Header word: frame counter right-aligned, marker bit and padding zero.
    function automatic logic [WORD_W-1:0] packHeader(input logic [FRM_W-1:0] frm);
        return {{(WORD_W - FRM_W){1'b0}}, frm};
    endfunction

endpackage

// File: rtl/orb_tog_det.sv
// Bank-toggle detector for the serializer's bank select.
// Ports:
//   iClkOrb  system clock
//   reset    asynchronous, active-low reset
//   iSwitch  serializer bank select
//   oTog     high for the cycle in which iSwitch differs from its last sampled value
module orb_tog_det (
    input  logic iClkOrb,
    input  logic reset,
    input  logic iSwitch,
    output logic oTog
);

    logic swD;

    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) begin
            swD <= 1'b0;
        end else begin
            swD <= iSwitch;
        end
    end

    assign oTog = swD ^ iSwitch;

endmodule

// File: rtl/orb_frame_filler.sv
// Fills the inactive half of the ping-pong frame RAM while the serializer
// reads the other half. On every bank toggle the freed bank is cleared,
// a frame-counter header is written at word 0 and then 11-bit samples are
// accepted over valid/ready into the remaining words.
// Ports:
//   iClkOrb  system clock (serializer domain)
//   reset    asynchronous, active-low reset
//   iSwitch  bank the serializer is reading
//   iData    sample payload
//   iVal     sample valid
//   oReady   sample accepted this cycle when iVal is high
//   oWrAddr  RAM write address {bank, word}
//   oWrData  RAM write data (bit 11 always 0)
//   oWrEn    RAM write strobe
//   oFrmCnt  frame counter
//   oFull    current bank completely filled
//   oOvf     pulse: sample offered while full and dropped
//   oUnder   pulse: toggle arrived before the bank was full
module orb_frame_filler #(
    parameter int          WORDS     = 2048,
    parameter int          AW        = 11,
    parameter logic [11:0] FILL_WORD = 12'h000,
    parameter bit          HDR_EN    = 1'b1
) (
    input  logic          iClkOrb,
    input  logic          reset,
    input  logic          iSwitch,
    input  logic [10:0]   iData,
    input  logic          iVal,
    output logic          oReady,
    output logic [AW:0]   oWrAddr,
    output logic [11:0]   oWrData,
    output logic          oWrEn,
    output logic [6:0]    oFrmCnt,
    output logic          oFull,
    output logic          oOvf,
    output logic          oUnder
);
    import orb_pkg::*;

    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

    fillState_t    state, stateNext;
    logic          wrBank, bankNext;
    logic [AW-1:0] addr, addrNext;
    logic          tog;
    logic          lastAddr;
    logic          wrEnNext;
    logic [AW:0]   wrAddrNext;
    logic [11:0]   wrDataNext;
    logic [6:0]    frmNext;
    logic          fullNext;
    logic          ovfNext;
    logic          underNext;

    orb_tog_det uTogDet (
        .iClkOrb (iClkOrb),
        .reset   (reset),
        .iSwitch (iSwitch),
        .oTog    (tog)
    );

    assign lastAddr = (addr == LAST_ADDR);

    // A toggle overrides everything else in its cycle: no write, no accept,
    // and the filler restarts on the bank the serializer just released.
    always_comb begin
        stateNext  = state;
        bankNext   = wrBank;
        addrNext   = addr;
        frmNext    = oFrmCnt;
        wrEnNext   = 1'b0;
        wrAddrNext = oWrAddr;
        wrDataNext = oWrData;
        fullNext   = oFull;
        ovfNext    = 1'b0;
        underNext  = 1'b0;
        oReady     = (state == FILL) && !tog;

        if (tog) begin
            stateNext = CLEAR;
            bankNext  = ~iSwitch;
            addrNext  = '0;
            frmNext   = oFrmCnt + 7'd1;
            fullNext  = 1'b0;
            underNext = (state != FULL);
        end else begin
            case (state)
                CLEAR: begin
                    wrEnNext   = 1'b1;
                    wrAddrNext = {wrBank, addr};
                    wrDataNext = FILL_WORD;
                    if (lastAddr) begin
                        addrNext  = '0;
                        stateNext = HDR_EN ? HDR : FILL;
                    end else begin
                        addrNext = addr + 1'b1;
                    end
                end
                HDR: begin
                    wrEnNext   = 1'b1;
                    wrAddrNext = {wrBank, {AW{1'b0}}};
                    wrDataNext = packHeader(oFrmCnt);
                    addrNext   = AW'(1);
                    stateNext  = FILL;
                end
                FILL: begin
                    if (iVal) begin
                        wrEnNext             = 1'b1;
                        wrAddrNext           = {wrBank, addr};
                        wrDataNext           = WORD_W'(iData);
                        wrDataNext[MARK_BIT] = 1'b0;
                        if (lastAddr) begin
                            stateNext = FULL;
                            fullNext  = 1'b1;
                        end else begin
                            addrNext = addr + 1'b1;
                        end
                    end
                end
                FULL: begin
                    ovfNext = iVal;
                end
                default: begin
                    stateNext = CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) begin
            state   <= CLEAR;
            wrBank  <= 1'b1;
            addr    <= '0;
            oFrmCnt <= '0;
            oWrEn   <= 1'b0;
            oWrAddr <= '0;
            oWrData <= '0;
            oFull   <= 1'b0;
            oOvf    <= 1'b0;
            oUnder  <= 1'b0;
        end else begin
            state   <= stateNext;
            wrBank  <= bankNext;
            addr    <= addrNext;
            oFrmCnt <= frmNext;
            oWrEn   <= wrEnNext;
            oWrAddr <= wrAddrNext;
            oWrData <= wrDataNext;
            oFull   <= fullNext;
            oOvf    <= ovfNext;
            oUnder  <= underNext;
        end
    end

endmodule

// File: tb/tb_orb_frame_filler.sv
// Self-checking bench for orb_frame_filler. A queue of expected RAM writes,
// built from the frame layout rules, is checked against every write strobe;
// a frame-counter model is checked every cycle; directed steps pin timing,
// pulse counts and literal header values.
module tb_orb_frame_filler;

    typedef struct packed {
        logic [11:0] a;
        logic [11:0] d;
    } wr_t;

    logic        clk;
    logic        rstN;
    logic        iSwitch;
    logic [10:0] iData;
    logic        iVal;
    logic        oReady;
    logic [11:0] oWrAddr;
    logic [11:0] oWrData;
    logic        oWrEn;
    logic [6:0]  oFrmCnt;
    logic        oFull;
    logic        oOvf;
    logic        oUnder;

    int  checks     = 0;
    int  errors     = 0;
    int  ovfCount   = 0;
    int  underCount = 0;
    int  modelFrm   = 0;
    logic prevSw    = 1'b0;
    wr_t expQ[$];
    wr_t expEntry;

    orb_frame_filler dut (
        .iClkOrb (clk),
        .reset   (rstN),
        .iSwitch (iSwitch),
        .iData   (iData),
        .iVal    (iVal),
        .oReady  (oReady),
        .oWrAddr (oWrAddr),
        .oWrData (oWrData),
        .oWrEn   (oWrEn),
        .oFrmCnt (oFrmCnt),
        .oFull   (oFull),
        .oOvf    (oOvf),
        .oUnder  (oUnder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic sw, input logic val, input logic [10:0] data);
        iSwitch = sw;
        iVal    = val;
        iData   = data;
    endtask

    // A freshly released bank: every word cleared in order, then the header.
    task automatic pushFrameClear(input logic bank, input int frm);
        wr_t e;
        for (int w = 0; w < 2048; w++) begin
            e.a = {bank, 11'(w)};
            e.d = 12'h000;
            expQ.push_back(e);
        end
        e.a = {bank, 11'h000};
        e.d = {5'b0, 7'(frm)};
        expQ.push_back(e);
    endtask

    task automatic pushSample(input logic bank, input int word, input logic [10:0] data);
        wr_t e;
        e.a = {bank, 11'(word)};
        e.d = {1'b0, data};
        expQ.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame counter: one increment per observed bank-select change, modulo 128.
    always @(posedge clk) begin
        if (!rstN) begin
            prevSw   = 1'b0;
            modelFrm = 0;
        end else if (iSwitch != prevSw) begin
            prevSw   = iSwitch;
            modelFrm = (modelFrm + 1) % 128;
        end
    end

    always @(negedge clk) begin
        if (!rstN) begin
            checkOutput("rstWrEn", oWrEn, 0);
            checkOutput("rstWrAddr", oWrAddr, 0);
            checkOutput("rstWrData", oWrData, 0);
            checkOutput("rstFrmCnt", oFrmCnt, 0);
            checkOutput("rstFull", oFull, 0);
            checkOutput("rstOvf", oOvf, 0);
            checkOutput("rstUnder", oUnder, 0);
            checkOutput("rstReady", oReady, 0);
        end else begin
            checkOutput("frmCnt", oFrmCnt, modelFrm);
            if (oOvf) ovfCount++;
            if (oUnder) underCount++;
            if (oWrEn) begin
                checkOutput("markBit", oWrData[11], 0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedWrite", oWrEn, 0);
                end else begin
                    expEntry = expQ.pop_front();
                    checkOutput("wrAddr", oWrAddr, expEntry.a);
                    checkOutput("wrData", oWrData, expEntry.d);
                end
            end
        end
    end

    initial begin
        int ovfBase;
        int underBase;

        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 11'h0);
        repeat (3) @(posedge clk);
        pushFrameClear(1'b1, 0);
        #1 rstN = 1'b1;

        // Clear of bank 1 on consecutive cycles, header visible 2049 edges later.
        waitCycles(2049);
        checkOutput("clrQueueLeft", expQ.size(), 1);
        checkOutput("hdr0WrEn", oWrEn, 1);
        checkOutput("hdr0Addr", oWrAddr, 12'h800);
        checkOutput("hdr0Data", oWrData, 12'h000);
        checkOutput("readyAfterHdr0", oReady, 1);

        // Stream the 2047 data words of frame 0.
        for (int k = 1; k < 2048; k++) begin
            applyStimulus(1'b0, 1'b1, 11'(k));
            pushSample(1'b1, k, 11'(k));
            #1;
            if (k == 1 || k == 2047) checkOutput("readyFill", oReady, 1);
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 1'b0, 11'h0);
        checkOutput("lastWrAddr", oWrAddr, 12'hFFF);
        checkOutput("lastWrData", oWrData, 12'h7FF);
        checkOutput("fullAfterLast", oFull, 1);
        checkOutput("readyWhenFull", oReady, 0);
        waitCycles(1);
        checkOutput("fillQueueLeft", expQ.size(), 0);

        // Three offered samples while full.
        ovfBase = ovfCount;
        applyStimulus(1'b0, 1'b1, 11'h155);
        waitCycles(3);
        applyStimulus(1'b0, 1'b0, 11'h0);
        waitCycles(3);
        checkOutput("ovfPulses", ovfCount - ovfBase, 3);
        checkOutput("fullHeld", oFull, 1);

        // Toggle after a full frame: bank 0 cleared, header 1, no underrun.
        applyStimulus(1'b1, 1'b0, 11'h0);
        pushFrameClear(1'b0, 1);
        #1;
        checkOutput("readyOnTog1", oReady, 0);
        waitCycles(2050);
        checkOutput("tog1QueueLeft", expQ.size(), 1);
        checkOutput("hdr1Addr", oWrAddr, 12'h000);
        checkOutput("hdr1Data", oWrData, 12'h001);
        checkOutput("frmCnt1", oFrmCnt, 7'd1);
        checkOutput("fullCleared", oFull, 0);
        checkOutput("noUnderAfterFull", underCount, 0);
        waitCycles(1);
        checkOutput("tog1QueueEmpty", expQ.size(), 0);
        checkOutput("readyAfterHdr1", oReady, 1);

        // Toggle mid-fill after 100 samples; the sample offered then is dropped.
        for (int k = 1; k <= 100; k++) begin
            applyStimulus(1'b1, 1'b1, 11'(k));
            pushSample(1'b0, k, 11'(k));
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 1'b1, 11'd101);
        pushFrameClear(1'b1, 2);
        #1;
        checkOutput("readyOnMidTog", oReady, 0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 11'h0);
        waitCycles(2049);
        checkOutput("midQueueLeft", expQ.size(), 1);
        checkOutput("midUnder", underCount, 1);
        checkOutput("frmCnt2", oFrmCnt, 7'd2);
        checkOutput("hdr2Data", oWrData, 12'h002);
        waitCycles(1);
        checkOutput("midQueueEmpty", expQ.size(), 0);

        // 126 back-to-back toggles bring the counter to 128, i.e. 0.
        underBase = underCount;
        for (int i = 0; i < 126; i++) begin
            applyStimulus(~iSwitch, 1'b0, 11'h0);
            @(posedge clk);
            #1;
        end
        pushFrameClear(1'b1, 0);
        waitCycles(2049);
        checkOutput("wrapQueueLeft", expQ.size(), 1);
        checkOutput("wrapUnders", underCount - underBase, 126);
        checkOutput("frmCntWrap", oFrmCnt, 7'd0);
        checkOutput("hdrWrapAddr", oWrAddr, 12'h800);
        checkOutput("hdrWrapData", oWrData, 12'h000);
        waitCycles(1);
        checkOutput("wrapQueueEmpty", expQ.size(), 0);
        checkOutput("readyAfterWrap", oReady, 1);
        checkOutput("totalUnders", underCount, 127);
        checkOutput("totalOvfs", ovfCount, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/orb_frame_filler.md
Name: orb_frame_filler

Overview:
- Upstream producer for the orbit frame serializer. It fills the inactive half of a 2×2048×12 ping-pong frame RAM while the serializer reads the other half.
- It tracks the serializer's bank toggle (oSwitch → iSwitch), zero-clears the newly freed bank and writes a frame-counter header at word 0.
- It then accepts 11-bit samples via valid/ready into words 1..WORDS-1. Bit 11 of every written word is always 0; the serializer owns it for marker insertion.

Parameters:
- WORDS, 2048, words per frame/bank (power of two)
- AW, 11, word address width (log2 WORDS)
- FILL_WORD, 12'h000, value written to every word during CLEAR
- HDR_EN, 1, 1 = word 0 carries the frame counter; 0 = word 0 is a normal data slot

Ports:
- iClkOrb  in  1  system clock, same domain as the serializer
- reset  in  1  asynchronous, active-low reset
- iSwitch  in  1  serializer bank select; the serializer reads bank iSwitch
- iData  in  11  sample payload
- iVal  in  1  sample valid
- oReady  out  1  block accepts a sample this cycle
- oWrAddr  out  12  RAM write address {bank, word[AW-1:0]}
- oWrData  out  12  RAM write data
- oWrEn  out  1  RAM write strobe
- oFrmCnt  out  7  current frame counter
- oFull  out  1  current bank completely filled
- oOvf  out  1  one-cycle pulse: sample offered while FULL, dropped
- oUnder  out  1  one-cycle pulse: toggle arrived before FULL

Behaviour:
- Clock and reset: single clock iClkOrb; reset is asynchronous, active-low. All state clears immediately on reset low.
- Reset values: state=CLEAR, wrBank=1, addr=0, swD=0, oFrmCnt=0, oWrEn=0, oWrAddr=0, oWrData=0, oFull=0, oOvf=0, oUnder=0, oReady=0.
- Toggle detect: swD registers iSwitch; tog = swD ^ iSwitch (combinational).
- On tog, from any state:
  - wrBank <= ~iSwitch; addr <= 0; state <= CLEAR
  - oFrmCnt <= oFrmCnt+1, wrapping 127→0
  - oUnder pulses the next cycle if the old state != FULL
  - oFull <= 0
  - tog has priority over any write/accept in the same cycle; a sample offered that cycle is not accepted because oReady is 0 on tog.
- CLEAR:
  - writes FILL_WORD to addr 0..WORDS-1, one per cycle, with oWrEn=1.
  - First write occurs the cycle after entry; WORDS cycles total.
  - After addr WORDS-1, go to HDR if HDR_EN, else FILL with addr=0.
- HDR: one cycle; writes {5'b0, oFrmCnt} to addr 0, sets addr=1, then goes to FILL.
- FILL:
  - oReady=1 combinationally (state==FILL && !tog).
  - On iVal&oReady in cycle t, cycle t+1 has oWrEn=1, oWrData={1'b0,iData}, oWrAddr={wrBank,addr}; addr increments.
  - After writing addr WORDS-1, go to FULL.
- FULL: oReady=0, oFull=1. iVal=1 gives an oOvf pulse the following cycle per offered cycle; the data is dropped.
- oReady=0 in CLEAR/HDR/FULL; upstream must hold iVal/iData until accepted.
- Write pipeline: oWrEn/oWrAddr/oWrData are registered, 1-cycle latency from the decision. oWrEn=0 on any cycle without a write.
- Address arithmetic: addr is AW bits, compared against WORDS-1, never wraps inside a frame.
- Fill time: one frame read takes WORDS×48 clocks (12 bits × 4 clocks). CLEAR+HDR (WORDS+1 cycles) always completes well before the next toggle in normal operation.

Decomposition:
- Package orb_pkg:
  - constants WORDS=2048, AW=11, WORD_W=12, MARK_BIT=11, FRM_W=7
  - state enum {CLEAR, HDR, FILL, FULL}
  - header-word packing function
- Sub-module orb_tog_det: swD register plus XOR, outputs tog. Shared with other consumers of the serializer's bank select.
- All other logic is in one module.

Test Plan:
- Reset release with iSwitch=0: 2048 writes of 12'h000 to 0x800..0xFFF on consecutive cycles, then header 12'h000 at 0x800, then oReady=1.
- Stream 2047 samples with iVal held high, iData=addr value: writes 0x801..0xFFF with data {0,iData}, oFull=1 after the last, oReady=0.
- In FULL, drive iVal=1 for 3 cycles: exactly 3 oOvf pulses, no oWrEn.
- Toggle iSwitch 0→1 after full: the cycle after the toggle, writes start at 0x000; oFrmCnt=1; header 12'h001 at 0x000; no oUnder.
- Toggle mid-FILL after 100 samples: oUnder pulse, CLEAR restarts on the opposite bank at word 0; the sample offered on the toggle cycle is not accepted.
- 128 toggles: oFrmCnt wraps 127→0; header of frame 128 = 12'h000.
